// File: rtl/pkt_demux_pkg.sv
// Shared constants and state type for the 1-to-4 packet demultiplexer.
package pkt_demux_pkg;
    localparam int NUM_OUT  = 4;
    localparam int DEST_W   = 2;
    localparam int DEST_LSB = 0;
    localparam int LEN_LSB  = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;
endpackage

// File: rtl/pkt_demux_1_to_4_if.sv
// Beat-stream bus for the demux: one input stream, four output streams.
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high; valid never waits on ready, and data is held while valid && !ready.
interface pkt_demux_1_to_4_if #(
    parameter int DATA_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
    logic [4*DATA_W-1:0] out_data;

    // Producer / consumer side (drives the input stream, accepts outputs)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Demux side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux channel.
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);
    // Valid sets on load and clears on drain; a load in the drain cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pkt_demux_1_to_4.sv
// Packet-level 1-to-4 demultiplexer. A header beat carries destination
// (bits [1:0]) and payload length (bits [LEN_W+1:2]); payload beats that
// follow are steered into the chosen channel's output slot.
// Optional per-channel completed-packet counters: define DEMUX_STATS_EN.
module pkt_demux_1_to_4
    import pkt_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pkt_demux_1_to_4_if.slave      bus,
    output logic                   busy,
    output logic                   pkt_done
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_OUT*8-1:0]   pkt_cnt
`endif
);
    state_t                state, state_nxt;
    logic [LEN_W-1:0]      remaining, remaining_nxt;
    logic [DEST_W-1:0]     dest, dest_nxt;
    logic                  done_nxt;
    logic                  accept;
    logic [NUM_OUT-1:0]    load;
    logic [NUM_OUT-1:0]    slot_valid;
    logic [NUM_OUT*DATA_W-1:0] slot_data;
    logic [DEST_W-1:0]     hdr_dest;
    logic [LEN_W-1:0]      hdr_len;

    assign hdr_dest = bus.in_data[DEST_LSB +: DEST_W];
    assign hdr_len  = bus.in_data[LEN_LSB +: LEN_W];

    // Input ready depends only on state and the target slot, never on in_valid.
    always_comb begin
        bus.in_ready = 1'b1;
        if (state == PAYLOAD)
            bus.in_ready = !slot_valid[dest] || bus.out_ready[dest];
    end

    assign accept = bus.in_valid && bus.in_ready;
    assign busy   = (state == PAYLOAD);

    // Next-state, remaining count, destination latch and slot loads.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        dest_nxt      = dest;
        done_nxt      = 1'b0;
        load          = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    dest_nxt = hdr_dest;
                    if (hdr_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        remaining_nxt = hdr_len;
                        state_nxt     = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    load[dest]    = 1'b1;
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers; pkt_done is the registered completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            dest      <= '0;
            pkt_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            dest      <= dest_nxt;
            pkt_done  <= done_nxt;
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_out_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (bus.in_data),
            .ready     (bus.out_ready[k]),
            .valid     (slot_valid[k]),
            .data      (slot_data[k*DATA_W +: DATA_W])
        );
    end

    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;

`ifdef DEMUX_STATS_EN
    logic [7:0] cnt [NUM_OUT];

    // Count completed packets per channel at the edge that raises pkt_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
        end else if (done_nxt) begin
            cnt[dest_nxt] <= cnt[dest_nxt] + 8'd1;
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
        assign pkt_cnt[k*8 +: 8] = cnt[k];
    end
`endif
endmodule
